// File: rtl/hdmi_pic_pkg.sv
// Shared definitions for the HDMI picture-ROM display path: coordinate width,
// default background colour, reader state encoding and pixel/timing bundles.
package hdmi_pic_pkg;

  // Pixel coordinate counters and window origins are this wide and wrap.
  localparam int COORD_W = 12;

  // Colour shown on active pixels that fall outside the image window.
  localparam logic [23:0] DEFAULT_BG = 24'h000000;

  // Reader state: idle until the first frame start, then running forever.
  typedef enum logic {
    WAIT_VS = 1'b0,
    RUN     = 1'b1
  } rd_state_t;

  // One RGB888 pixel laid out as {R, G, B}.
  typedef logic [23:0] rgb888_t;

  // Timing bits that travel together through the latency-matching delay.
  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
    logic in_win;
  } tim_bits_t;

  // Position relative to a window origin. Unsigned wrap makes anything left
  // of / above the origin come out huge, so one compare covers both sides.
  function automatic logic [COORD_W-1:0] coord_offset(
    input logic [COORD_W-1:0] pos,
    input logic [COORD_W-1:0] origin
  );
    return pos - origin;
  endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift register used to keep timing bits aligned with the ROM
// read pipeline. Exposes the last stage and the stage just before it so a
// registered consumer can line up with the final tap.
module sig_delay #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_pre
);

  // stage_reg[0] is the newest sample, stage_reg[DEPTH-1] the oldest.
  logic [DEPTH-1:0][WIDTH-1:0] stage_reg;

  // Shift one stage per clock; reset empties the whole pipe at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[DEPTH-2:0], din};
    end
  end

  assign dout     = stage_reg[DEPTH-1];
  assign dout_pre = stage_reg[DEPTH-2];

endmodule

// File: rtl/hdmi_pic_rom_reader.sv
// Picture-ROM reader: follows raw vs/hs/de timing, tracks the pixel position,
// addresses the external picture ROM for a movable image window and emits
// RGB pixels with the timing outputs delayed to match the ROM read latency.
module hdmi_pic_rom_reader
  import hdmi_pic_pkg::*;
#(
  parameter int                    IMG_W      = 256,
  parameter int                    IMG_H      = 256,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 24,
  parameter int                    ROM_LAT    = 2,
  parameter logic [DATA_WIDTH-1:0] BG_COLOR   = DEFAULT_BG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vs_in,
  input  logic                  hs_in,
  input  logic                  de_in,
  input  logic [COORD_W-1:0]    x_start,
  input  logic [COORD_W-1:0]    y_start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  vs_out,
  output logic                  hs_out,
  output logic                  de_out,
  output logic [DATA_WIDTH-1:0] rgb_out
);

  // Address register, ROM_LAT cycles of ROM, then the output register.
  localparam int LAT = ROM_LAT + 2;
  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H);

  // Window sizes one bit wider than a coordinate so a full-range size fits.
  localparam logic [COORD_W:0] IMG_W_LIM = (COORD_W + 1)'(IMG_W);
  localparam logic [COORD_W:0] IMG_H_LIM = (COORD_W + 1)'(IMG_H);

  rd_state_t             state_reg;
  logic                  vs_prev_reg;
  logic                  de_prev_reg;
  logic [COORD_W-1:0]    x_cnt_reg;
  logic [COORD_W-1:0]    y_cnt_reg;
  logic [COORD_W-1:0]    xs_reg;
  logic [COORD_W-1:0]    ys_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] rgb_reg;

  logic                  vs_rise;
  logic                  running;
  logic [COORD_W-1:0]    x_pos;
  logic [COORD_W-1:0]    y_pos;
  logic [COORD_W-1:0]    xs_cur;
  logic [COORD_W-1:0]    ys_cur;
  logic [COORD_W-1:0]    dx;
  logic [COORD_W-1:0]    dy;
  logic                  in_win;

  tim_bits_t             dly_in;
  tim_bits_t             dly_out;
  tim_bits_t             dly_pre;
  logic                  unused_taps;

  // A frame start overrides the counters for the current pixel, so a
  // malformed vs rise coinciding with de is treated as pixel (0,0) of the new
  // frame with the freshly presented window origin.
  assign vs_rise = vs_in & ~vs_prev_reg;
  assign running = (state_reg == RUN) | vs_rise;
  assign x_pos   = vs_rise ? '0      : x_cnt_reg;
  assign y_pos   = vs_rise ? '0      : y_cnt_reg;
  assign xs_cur  = vs_rise ? x_start : xs_reg;
  assign ys_cur  = vs_rise ? y_start : ys_reg;

  assign dx = coord_offset(x_pos, xs_cur);
  assign dy = coord_offset(y_pos, ys_cur);

  // Clipping falls out naturally: pixels outside the active area never have
  // de, and window pixels that are visible keep their true offsets.
  assign in_win = running & de_in
                & ({1'b0, dx} < IMG_W_LIM)
                & ({1'b0, dy} < IMG_H_LIM);

  // Frame/line tracking: wait for the first frame start, then count pixels
  // within a line and lines within a frame; window origin sampled per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= WAIT_VS;
      vs_prev_reg <= 1'b0;
      de_prev_reg <= 1'b0;
      x_cnt_reg   <= '0;
      y_cnt_reg   <= '0;
      xs_reg      <= '0;
      ys_reg      <= '0;
    end else begin
      vs_prev_reg <= vs_in;
      de_prev_reg <= de_in;
      if (vs_rise) begin
        state_reg <= RUN;
        xs_reg    <= x_start;
        ys_reg    <= y_start;
        y_cnt_reg <= '0;
        // The rising-edge pixel itself, if any, occupied column 0.
        x_cnt_reg <= de_in ? COORD_W'(1) : '0;
      end else if (de_in) begin
        x_cnt_reg <= x_cnt_reg + COORD_W'(1);
      end else if (de_prev_reg) begin
        x_cnt_reg <= '0;
        y_cnt_reg <= y_cnt_reg + COORD_W'(1);
      end
    end
  end

  // ROM address: row offset in the high bits, column offset in the low bits;
  // holds its last value whenever the current pixel is outside the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg <= '0;
    end else if (in_win) begin
      addr_reg <= {dy[YW-1:0], dx[XW-1:0]};
    end
  end

  assign rom_addr = addr_reg;

  assign dly_in = '{vs: vs_in, hs: hs_in, de: de_in, in_win: in_win};

  sig_delay #(
    .WIDTH ($bits(tim_bits_t)),
    .DEPTH (LAT)
  ) u_sig_delay (
    .clk      (clk),
    .rst      (rst),
    .din      (dly_in),
    .dout     (dly_out),
    .dout_pre (dly_pre)
  );

  // Output pixel, registered from the stage one short of the full delay so
  // it lands in the same cycle as the delayed timing bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_reg <= '0;
    end else if (!dly_pre.de) begin
      rgb_reg <= '0;
    end else if (dly_pre.in_win) begin
      rgb_reg <= rom_data;
    end else begin
      rgb_reg <= BG_COLOR;
    end
  end

  assign rgb_out = rgb_reg;
  assign vs_out  = dly_out.vs;
  assign hs_out  = dly_out.hs;
  assign de_out  = dly_out.de;

  // Sync bits at the early tap and the window flag at the last tap have no
  // consumer; the output mux only needs de/in_win one stage early.
  assign unused_taps = ^{dly_pre.vs, dly_pre.hs, dly_out.in_win};

endmodule
